multi_pulse_gen: RTL and testbench
==================================

// Module: multi_pulse_gen
// PURPOSE
//  Parametrised successor to the double-pulse GPIO generator. An edge on the asynchronous
//  trigger arms one burst of NUM_PULSES programmable pulses, timed in clk cycles.
//  Drives a masked GPIO bank on the board I/O; start/end times come from UART-loaded regs.
//  Adds validated, latched timing, busy/done status and a clean single-shot FSM.
// PARAMETERS
//  CNT_W      32  width of time counter and of every start/end value (cycles)
//  NUM_PULSES  2  pulses per burst (>=1)
//  GPIO_W      6  GPIO bank width
//  TRIG_EDGE   0  0 = falling edge of trig_in starts a burst, 1 = rising edge
// PORTS
//  clk         in   1                  system clock (50 MHz on board)
//  rst_n       in   1                  asynchronous active-low reset
//  trig_in     in   1                  asynchronous start request; synchronised internally
//  start_time  in   NUM_PULSES*CNT_W   pulse i rise time, slice [i*CNT_W +: CNT_W]
//  end_time    in   NUM_PULSES*CNT_W   pulse i fall time, same slicing
//  gpio_mask   in   GPIO_W             bits driven by the pulse; others held 0
//  gpio        out  GPIO_W             pulse output (registered)
//  busy        out  1                  burst in progress
//  done        out  1                  1-cycle strobe at burst end
//  cfg_err     out  1                  sticky: last trigger rejected for bad timing
// BEHAVIOUR
//  - Reset (async, any time incl. mid-burst): gpio=0, busy=0, done=0, cfg_err=0,
//    counter=0, FSM=IDLE, sync flops=0. No pulse resumes after reset release.
//  - trig_in -> 2-FF sync -> edge detect; trig_evt asserts 3 clk after the edge.
//  - FSM IDLE: on trig_evt, latch start_time/end_time/gpio_mask and validate:
//    start_i < end_i for all i, end_i <= start_(i+1) for i<NUM_PULSES-1.
//    Valid -> RUN, counter=0, busy=1, cfg_err=0. Invalid -> stay IDLE, cfg_err=1.
//  - RUN: counter increments by 1 per clk. gpio <= mask when counter==start_i,
//    gpio <= 0 when counter==end_i; pulse i is high exactly end_i-start_i cycles,
//    rising one clk after counter==start_i. Back-to-back pulses (end_i==start_(i+1))
//    stay high continuously.
//  - When counter==end_(NUM_PULSES-1): next edge gpio=0, busy=0, done=1 (1 clk), -> IDLE.
//  - Inputs changed during RUN have no effect (latched copy used). trig_evt during RUN
//    ignored; trig_evt in the same cycle done asserts is ignored too.
//  - start_0==0 allowed: gpio rises on the first clk after entering RUN.
//  - Counter never wraps: validated end_last <= 2^CNT_W-1 bounds the burst.
// CONFIGURATION
//  MULTI_PULSE_GEN_REPEAT_EN defined: adds ports period (in, CNT_W) and repeat_n (in, 8),
//    latched with timing. After end_last, counter continues to period-1, then restarts
//    at 0. The burst runs repeat_n+1 times in total; done pulses only after the final one.
//    Validation also requires end_last < period.
//  Not defined: single-shot as above; no extra ports.
// STRUCTURE
//  Package multi_pulse_gen_pkg: FSM state enum {IDLE, RUN}, SYNC_STAGES=2 localparam,
//    slice helper function for start/end extraction.
//  Sub-module pulse_trig_sync (2-FF synchroniser + edge detect, TRIG_EDGE parameter);
//    validator and comparators stay inline (generate loop over NUM_PULSES).
// TESTING
//  1 defaults, start={100,10}, end={150,50} (pulse0 10..50, pulse1 100..150), fall on
//    trig_in -> gpio=6'h3F for 40 clk, 0 for 50, 6'h3F for 50; done 1 clk after end_1.
//  2 start_1=50=end_0 -> gpio high continuously cycles 10..150, single rising edge.
//  3 end_0=start_0=20 -> no burst, busy stays 0, cfg_err=1; next valid trigger clears it.
//  4 second trig_in edge at counter=30 and start_time rewritten mid-burst -> waveform
//    identical to test 1, exactly one done.
//  5 rst_n low at counter=120 -> gpio=0, busy=0 immediately; no activity after release.
//  6 REPEAT_EN, period=200, repeat_n=2 -> 3 bursts starting 200 clk apart, one done.

Source files
------------

// File: rtl/multi_pulse_gen_pkg.sv
// Shared types and helpers for the multi-pulse GPIO burst generator.
package multi_pulse_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned SYNC_STAGES = 2;

  // LSB position of pulse idx within a packed start/end timing bus.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/pulse_trig_sync.sv
// Trigger synchroniser and single-edge detector; the event strobe is registered,
// so it appears three clk edges after the trig_in edge.
module pulse_trig_sync
  import multi_pulse_gen_pkg::*;
#(
  parameter bit TRIG_EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig_in,
  output logic trig_evt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;
  logic                   evt_q;
  logic                   edge_det;

  assign edge_det = TRIG_EDGE ? ( sync_q[SYNC_STAGES-1] & ~last_q)
                              : (~sync_q[SYNC_STAGES-1] &  last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
      evt_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], trig_in};
      last_q <= sync_q[SYNC_STAGES-1];
      evt_q  <= edge_det;
    end
  end

  assign trig_evt = evt_q;

endmodule

// File: rtl/multi_pulse_gen.sv
// Burst generator: one trigger edge produces NUM_PULSES masked GPIO pulses.
// Optional repeat mode is enabled with `define MULTI_PULSE_GEN_REPEAT_EN.
module multi_pulse_gen
  import multi_pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned NUM_PULSES = 2,
  parameter int unsigned GPIO_W     = 6,
  parameter bit          TRIG_EDGE  = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        trig_in,
  input  logic [NUM_PULSES*CNT_W-1:0] start_time,
  input  logic [NUM_PULSES*CNT_W-1:0] end_time,
  input  logic [GPIO_W-1:0]           gpio_mask,
  output logic [GPIO_W-1:0]           gpio,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_err
`ifdef MULTI_PULSE_GEN_REPEAT_EN
  ,
  input  logic [CNT_W-1:0]            period,
  input  logic [7:0]                  repeat_n
`endif
);

  localparam int unsigned LAST_LO = slice_lo(NUM_PULSES - 1, CNT_W);

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [NUM_PULSES*CNT_W-1:0] start_q, start_d;
  logic [NUM_PULSES*CNT_W-1:0] end_q, end_d;
  logic [GPIO_W-1:0]           mask_q, mask_d;
  logic [GPIO_W-1:0]           gpio_q, gpio_d;
  logic                        done_q, done_d;
  logic                        cfg_err_q, cfg_err_d;
`ifdef MULTI_PULSE_GEN_REPEAT_EN
  logic [CNT_W-1:0]            period_q, period_d;
  logic [7:0]                  rep_n_q, rep_n_d;
  logic [7:0]                  rep_q, rep_d;
`endif

  logic                        trig_evt;
  logic [NUM_PULSES-1:0]       ok_order;
  logic [NUM_PULSES-1:0]       ok_link;
  logic [NUM_PULSES-1:0]       hit_start;
  logic [NUM_PULSES-1:0]       hit_end;
  logic                        timing_ok;
  logic [CNT_W-1:0]            end_last;

  pulse_trig_sync #(
    .TRIG_EDGE(TRIG_EDGE)
  ) u_trig_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .trig_in (trig_in),
    .trig_evt(trig_evt)
  );

  // Validation looks at the live inputs; the comparators look at the latched copy.
  for (genvar gi = 0; gi < NUM_PULSES; gi++) begin : g_pulse
    localparam int unsigned LO = slice_lo(gi, CNT_W);

    assign ok_order[gi]  = start_time[LO +: CNT_W] < end_time[LO +: CNT_W];
    assign hit_start[gi] = cnt_q == start_q[LO +: CNT_W];
    assign hit_end[gi]   = cnt_q == end_q[LO +: CNT_W];

    if (gi < NUM_PULSES - 1) begin : g_link
      assign ok_link[gi] = end_time[LO +: CNT_W] <= start_time[LO + CNT_W +: CNT_W];
    end else begin : g_last
      assign ok_link[gi] = 1'b1;
    end
  end

`ifdef MULTI_PULSE_GEN_REPEAT_EN
  assign timing_ok = (&ok_order) & (&ok_link) & (end_time[LAST_LO +: CNT_W] < period);
`else
  assign timing_ok = (&ok_order) & (&ok_link);
`endif

  assign end_last = end_q[LAST_LO +: CNT_W];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start_d   = start_q;
    end_d     = end_q;
    mask_d    = mask_q;
    gpio_d    = gpio_q;
    done_d    = 1'b0;
    cfg_err_d = cfg_err_q;
`ifdef MULTI_PULSE_GEN_REPEAT_EN
    period_d  = period_q;
    rep_n_d   = rep_n_q;
    rep_d     = rep_q;
`endif

    unique case (state_q)
      IDLE: begin
        // The done cycle also blocks a trigger so a burst never chains into the next.
        if (trig_evt && !done_q) begin
          if (timing_ok) begin
            start_d   = start_time;
            end_d     = end_time;
            mask_d    = gpio_mask;
`ifdef MULTI_PULSE_GEN_REPEAT_EN
            period_d  = period;
            rep_n_d   = repeat_n;
            rep_d     = 8'd0;
`endif
            cnt_d     = '0;
            cfg_err_d = 1'b0;
            state_d   = RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      RUN: begin
        cnt_d = cnt_q + 1'b1;
        // Rise wins over fall so abutting pulses merge into one continuous high.
        if (|hit_start) begin
          gpio_d = mask_q;
        end else if (|hit_end) begin
          gpio_d = '0;
        end

`ifdef MULTI_PULSE_GEN_REPEAT_EN
        if (cnt_q == period_q - 1'b1) begin
          cnt_d = '0;
          rep_d = rep_q + 8'd1;
        end
        if ((cnt_q == end_last) && (rep_q == rep_n_q)) begin
          gpio_d  = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
`else
        if (cnt_q == end_last) begin
          gpio_d  = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
`endif
      end

      default: begin
        state_d = IDLE;
        gpio_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      start_q   <= '0;
      end_q     <= '0;
      mask_q    <= '0;
      gpio_q    <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
`ifdef MULTI_PULSE_GEN_REPEAT_EN
      period_q  <= '0;
      rep_n_q   <= '0;
      rep_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      end_q     <= end_d;
      mask_q    <= mask_d;
      gpio_q    <= gpio_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
`ifdef MULTI_PULSE_GEN_REPEAT_EN
      period_q  <= period_d;
      rep_n_q   <= rep_n_d;
      rep_q     <= rep_d;
`endif
    end
  end

  assign gpio    = gpio_q;
  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Scoreboard bench for multi_pulse_gen: stimulus queues timed output events,
// a monitor pops and compares every observed output change.
module tb_multi_pulse_gen;

  typedef struct {
    int unsigned cyc;
    int          sig;
    logic [5:0]  val;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig_in = 1'b1;
  logic [63:0] start_time;
  logic [63:0] end_time;
  logic [5:0]  gpio_mask;
  logic [5:0]  gpio;
  logic        busy;
  logic        done;
  logic        cfg_err;
`ifdef MULTI_PULSE_GEN_REPEAT_EN
  logic [31:0] period;
  logic [7:0]  repeat_n;
`endif

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  ev_t         exp_q[$];
  logic [5:0]  prev_gpio = '0;
  logic        prev_busy = 1'b0;
  logic        prev_done = 1'b0;
  logic        prev_err = 1'b0;
  string       sig_name[4] = '{"gpio", "busy", "done", "cfg_err"};

  multi_pulse_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .trig_in   (trig_in),
    .start_time(start_time),
    .end_time  (end_time),
    .gpio_mask (gpio_mask),
    .gpio      (gpio),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err)
`ifdef MULTI_PULSE_GEN_REPEAT_EN
    ,
    .period    (period),
    .repeat_n  (repeat_n)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic void exp_ev(input int unsigned c, input int s, input logic [5:0] v);
    ev_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    exp_q.push_back(e);
  endfunction

  task automatic observe(input int s, input logic [5:0] v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: %s=%0h at cyc %0d, required no change", sig_name[s], v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.sig != s || e.cyc != cyc || e.val != v) begin
        errors++;
        $display("FAIL event: got %s=%0h at cyc %0d, required %s=%0h at cyc %0d",
                 sig_name[s], v, cyc, sig_name[e.sig], e.val, e.cyc);
      end
    end
  endtask

  // Monitor: runs just after each falling edge, away from the active edge.
  always begin
    @(negedge clk);
    #1;
    if (gpio !== prev_gpio) begin observe(0, gpio); prev_gpio = gpio; end
    if (busy !== prev_busy) begin observe(1, {5'd0, busy}); prev_busy = busy; end
    if (done !== prev_done) begin observe(2, {5'd0, done}); prev_done = done; end
    if (cfg_err !== prev_err) begin observe(3, {5'd0, cfg_err}); prev_err = cfg_err; end
  end

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0b, required %0b", name, act, req);
    end
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d events pending after %0d cycles, required 0", exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic fall_trig(output int unsigned t);
    @(negedge clk);
    trig_in = 1'b0;
    t = cyc;
  endtask

  task automatic rise_trig();
    @(negedge clk);
    trig_in = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  // Standard burst: pulse0 10..50, pulse1 100..150, full mask.
  function automatic void push_std(input int unsigned t, input bit clr_err);
    exp_ev(t + 4, 1, 6'd1);
    if (clr_err) exp_ev(t + 4, 3, 6'd0);
    exp_ev(t + 15,  0, 6'h3F);
    exp_ev(t + 55,  0, 6'h00);
    exp_ev(t + 105, 0, 6'h3F);
    exp_ev(t + 155, 0, 6'h00);
    exp_ev(t + 155, 1, 6'd0);
    exp_ev(t + 155, 2, 6'd1);
    exp_ev(t + 156, 2, 6'd0);
  endfunction

  task automatic load_std();
    start_time = {32'd100, 32'd10};
    end_time   = {32'd150, 32'd50};
    gpio_mask  = 6'h3F;
  endtask

  initial begin
    int unsigned t;
    load_std();
`ifdef MULTI_PULSE_GEN_REPEAT_EN
    period   = 32'd1000;
    repeat_n = 8'd0;
`endif
    repeat (3) @(negedge clk);
    #1;
    check1("reset_gpio0", gpio[0], 1'b0);
    check1("reset_gpio5", gpio[5], 1'b0);
    check1("reset_busy", busy, 1'b0);
    check1("reset_done", done, 1'b0);
    check1("reset_cfg_err", cfg_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Test 1: basic two-pulse burst.
    fall_trig(t);
    push_std(t, 1'b0);
    wait_drain(400);
    rise_trig();

    // Test 2: abutting pulses merge.
    start_time = {32'd50, 32'd10};
    fall_trig(t);
    exp_ev(t + 4,   1, 6'd1);
    exp_ev(t + 15,  0, 6'h3F);
    exp_ev(t + 155, 0, 6'h00);
    exp_ev(t + 155, 1, 6'd0);
    exp_ev(t + 155, 2, 6'd1);
    exp_ev(t + 156, 2, 6'd0);
    wait_drain(400);
    rise_trig();

    // Test 3: zero-width pulse rejected, then a valid trigger clears the error.
    start_time = {32'd100, 32'd20};
    end_time   = {32'd150, 32'd20};
    fall_trig(t);
    exp_ev(t + 4, 3, 6'd1);
    wait_drain(100);
    check1("invalid_busy", busy, 1'b0);
    rise_trig();
    load_std();
    fall_trig(t);
    push_std(t, 1'b1);
    wait_drain(400);
    rise_trig();

    // Test 4: retrigger and input rewrite mid-burst, trigger coinciding with done.
    fall_trig(t);
    push_std(t, 1'b0);
    wait_cyc(t + 34);
    trig_in    = 1'b1;
    start_time = {32'd7, 32'd3};
    gpio_mask  = 6'h01;
    wait_cyc(t + 40);
    trig_in = 1'b0;
    wait_cyc(t + 140);
    trig_in = 1'b1;
    wait_cyc(t + 152);
    trig_in = 1'b0;
    wait_drain(400);
    check1("no_retrigger_after_done", busy, 1'b0);
    load_std();
    rise_trig();

`ifdef MULTI_PULSE_GEN_REPEAT_EN
    // Test 6: three repeated bursts 200 cycles apart, single done.
    period   = 32'd200;
    repeat_n = 8'd2;
    fall_trig(t);
    exp_ev(t + 4, 1, 6'd1);
    for (int b = 0; b < 3; b++) begin
      exp_ev(t + 200 * b + 15,  0, 6'h3F);
      exp_ev(t + 200 * b + 55,  0, 6'h00);
      exp_ev(t + 200 * b + 105, 0, 6'h3F);
      exp_ev(t + 200 * b + 155, 0, 6'h00);
    end
    exp_ev(t + 555, 1, 6'd0);
    exp_ev(t + 555, 2, 6'd1);
    exp_ev(t + 556, 2, 6'd0);
    wait_drain(900);
    period   = 32'd1000;
    repeat_n = 8'd0;
    rise_trig();
`endif

    // Test 5: async reset mid pulse 1 kills the burst for good.
    fall_trig(t);
    exp_ev(t + 4,   1, 6'd1);
    exp_ev(t + 15,  0, 6'h3F);
    exp_ev(t + 55,  0, 6'h00);
    exp_ev(t + 105, 0, 6'h3F);
    wait_cyc(t + 124);
    rst_n = 1'b0;
    exp_ev(t + 124, 0, 6'h00);
    exp_ev(t + 124, 1, 6'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    wait_drain(10);
    check1("post_reset_busy", busy, 1'b0);
    check1("post_reset_cfg_err", cfg_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
